ble_command_parser: RTL

Receives 8N1 UART bytes from the BLE module and decodes fixed-length, checksummed command frames. Holds the registered control parameters consumed by the PID control loop and the motor enable: pitch/yaw PID gains, pitch/yaw setpoints, and `run_en`. Sits between the `BLE_UART_TX` pin and the control loop / motor drivers. It replaces the constant gain, setpoint and enable tie-offs at the top level.

---
 rtl/ble_pkg.sv | 45 ++++
 rtl/ble_command_parser_uart_rx.sv | 126 ++++++++++++
 rtl/ble_command_parser.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ble_pkg.sv
// Shared types and helpers for the BLE command parser and its UART receiver.
package ble_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [7:0] {
    REG_PITCH_KP  = 8'h01,
    REG_PITCH_KI  = 8'h02,
    REG_PITCH_KD  = 8'h03,
    REG_YAW_KP    = 8'h04,
    REG_YAW_KI    = 8'h05,
    REG_YAW_KD    = 8'h06,
    REG_SET_PITCH = 8'h07,
    REG_SET_YAW   = 8'h08,
    REG_RUN_EN    = 8'h09
  } ble_reg_id_t;

  typedef enum logic [2:0] {
    HUNT,
    ID,
    HI,
    LO,
    CHK
  } parse_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Clamp a 16-bit signed command value into the 9-bit signed register range.
  function automatic logic signed [8:0] sat9(input logic signed [15:0] v);
    if (v > 16'sd255) begin
      return 9'sh0FF;
    end else if (v < -16'sd256) begin
      return 9'sh100;
    end else begin
      return v[8:0];
    end
  endfunction

endpackage

// File: rtl/ble_command_parser_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, stop-bit framing check.
module uart_rx
  import ble_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_error
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CNT_W   = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYC / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CYC - 1);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;

  // Synchronizer flops reset low so a start edge is only seen after the line was genuinely high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = RX_START;
          cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (!rx_sync_q) begin
            state_d = RX_DATA;
            cnt_d   = FULL_M1;
            bit_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = FULL_M1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          if (rx_sync_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data   = shift_q;
  assign byte_valid  = valid_q;
  assign frame_error = ferr_q;

endmodule

// File: rtl/ble_command_parser.sv
// Decodes checksummed 5-byte BLE command frames into the PID gain, setpoint and run-enable registers.
module ble_command_parser
  import ble_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic signed [8:0] pitch_kP,
  output logic signed [8:0] pitch_kI,
  output logic signed [8:0] pitch_kD,
  output logic signed [8:0] yaw_kP,
  output logic signed [8:0] yaw_kI,
  output logic signed [8:0] yaw_kD,
  output logic signed [8:0] set_pitch,
  output logic signed [8:0] set_yaw,
  output logic              run_en,
  output logic              update,
  output logic              frame_err
);

  localparam int BIT_CYC     = CLK_HZ / BAUD;
  localparam int TIMEOUT_CYC = TIMEOUT_BITS * BIT_CYC;
  localparam int TMO_W       = $clog2(TIMEOUT_CYC + 1);

  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       rx_ferr;

  uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_data  (rx_byte),
    .byte_valid (rx_vld),
    .frame_error(rx_ferr)
  );

  parse_state_t      state_q, state_d;
  logic [7:0]        id_q, id_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        lo_q, lo_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic signed [8:0] pkp_q, pkp_d, pki_q, pki_d, pkd_q, pkd_d;
  logic signed [8:0] ykp_q, ykp_d, yki_q, yki_d, ykd_q, ykd_d;
  logic signed [8:0] sp_q, sp_d, sy_q, sy_d;
  logic              run_q, run_d;
  logic              upd_q, upd_d;
  logic              ferr_q, ferr_d;

  logic signed [8:0] frame_val;
  logic              chk_ok;
  logic              id_hit;

  assign frame_val = sat9($signed({hi_q, lo_q}));
  assign chk_ok    = (rx_byte == (id_q ^ hi_q ^ lo_q));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      id_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      tmo_q   <= '0;
      pkp_q   <= '0;
      pki_q   <= '0;
      pkd_q   <= '0;
      ykp_q   <= '0;
      yki_q   <= '0;
      ykd_q   <= '0;
      sp_q    <= '0;
      sy_q    <= '0;
      run_q   <= 1'b0;
      upd_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      tmo_q   <= tmo_d;
      pkp_q   <= pkp_d;
      pki_q   <= pki_d;
      pkd_q   <= pkd_d;
      ykp_q   <= ykp_d;
      yki_q   <= yki_d;
      ykd_q   <= ykd_d;
      sp_q    <= sp_d;
      sy_q    <= sy_d;
      run_q   <= run_d;
      upd_q   <= upd_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    tmo_d   = '0;
    pkp_d   = pkp_q;
    pki_d   = pki_q;
    pkd_d   = pkd_q;
    ykp_d   = ykp_q;
    yki_d   = yki_q;
    ykd_d   = ykd_q;
    sp_d    = sp_q;
    sy_d    = sy_q;
    run_d   = run_q;
    upd_d   = 1'b0;
    ferr_d  = 1'b0;
    id_hit  = 1'b1;

    // A UART framing error always pulses frame_err and abandons any partial frame.
    if (rx_ferr) begin
      state_d = HUNT;
      ferr_d  = 1'b1;
    end else if (rx_vld) begin
      unique case (state_q)
        HUNT: if (rx_byte == SYNC_BYTE) state_d = ID;
        ID: begin
          id_d    = rx_byte;
          state_d = HI;
        end
        HI: begin
          hi_d    = rx_byte;
          state_d = LO;
        end
        LO: begin
          lo_d    = rx_byte;
          state_d = CHK;
        end
        CHK: begin
          state_d = HUNT;
          if (chk_ok) begin
            case (id_q)
              REG_PITCH_KP:  pkp_d = frame_val;
              REG_PITCH_KI:  pki_d = frame_val;
              REG_PITCH_KD:  pkd_d = frame_val;
              REG_YAW_KP:    ykp_d = frame_val;
              REG_YAW_KI:    yki_d = frame_val;
              REG_YAW_KD:    ykd_d = frame_val;
              REG_SET_PITCH: sp_d  = frame_val;
              REG_SET_YAW:   sy_d  = frame_val;
              REG_RUN_EN:    run_d = lo_q[0];
              default:       id_hit = 1'b0;
            endcase
          end
          if (chk_ok && id_hit) upd_d = 1'b1;
          else                  ferr_d = 1'b1;
        end
        default: state_d = HUNT;
      endcase
    end else if (state_q != HUNT) begin
      // Stalled mid-frame: give up silently once the idle gap exceeds the limit.
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d = HUNT;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  assign pitch_kP  = pkp_q;
  assign pitch_kI  = pki_q;
  assign pitch_kD  = pkd_q;
  assign yaw_kP    = ykp_q;
  assign yaw_kI    = yki_q;
  assign yaw_kD    = ykd_q;
  assign set_pitch = sp_q;
  assign set_yaw   = sy_q;
  assign run_en    = run_q;
  assign update    = upd_q;
  assign frame_err = ferr_q;

endmodule
